// File: rtl/aes_key_sched_seq.sv
// aes_key_sched_seq: iterative AES-128 key schedule (forward from round 0 or inverse from round MAX_ROUND); start/mode/target_round/key_in in, busy/done/err/key_out/round_out out
module aes_key_sched_seq #(
  parameter int MAX_ROUND       = 10,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [3:0]   target_round,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] key_out,
  output logic [3:0]   round_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] MAXR = 4'(MAX_ROUND);
  localparam logic [79:0] RCON = 80'h01020408102040801b36;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  state_t state, state_nx;
  logic mode_q, err_q, accept, reject, zero_n;
  logic [3:0] tgt_q, step_rnd;
  logic [127:0] step_key;
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r, o;
    r = {w[23:0], w[31:24]};
    for (int b = 0; b < 4; b++) o[8*b +: 8] = SBOX[8*(255 - int'(r[8*b +: 8])) +: 8];
    return o;
  endfunction
  function automatic logic [31:0] rcon(input logic [3:0] i);
    return (i < 4'd10) ? {RCON[8*(9 - int'(i)) +: 8], 24'h0} : 32'h0;
  endfunction
  function automatic logic [127:0] fwd(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] a, b, c, d;
    a = k[127:96] ^ sub_rot(k[31:0]) ^ rcon(i);
    b = k[95:64] ^ a;
    c = k[63:32] ^ b;
    d = k[31:0] ^ c;
    return {a, b, c, d};
  endfunction
  // Undo one forward step: recover w3..w1 first, then w0 needs the recovered w3.
  function automatic logic [127:0] inv(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] a, b, c, d;
    d = k[31:0] ^ k[63:32];
    c = k[63:32] ^ k[95:64];
    b = k[95:64] ^ k[127:96];
    a = k[127:96] ^ sub_rot(d) ^ rcon(r - 4'd1);
    return {a, b, c, d};
  endfunction
  // Unrolled step chain; each stage is skipped once the target is reached.
  always_comb begin
    step_key = key_out;
    step_rnd = round_out;
    for (int s = 0; s < STEPS_PER_CYCLE; s++)
      if (step_rnd != tgt_q) begin
        step_key = mode_q ? inv(step_key, step_rnd) : fwd(step_key, step_rnd);
        step_rnd = mode_q ? step_rnd - 4'd1 : step_rnd + 4'd1;
      end
  end
  assign accept = start && state != RUN && target_round <= MAXR;
  assign reject = start && state != RUN && target_round > MAXR;
  assign zero_n = mode ? target_round == MAXR : target_round == 4'd0;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx = accept ? (zero_n ? DONE : RUN) :
               reject ? IDLE :
               state == RUN ? (step_rnd == tgt_q ? DONE : RUN) : IDLE;
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
    err  = err_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_out   <= '0;
      round_out <= '0;
      mode_q    <= 1'b0;
      tgt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        key_out   <= key_in;
        round_out <= mode ? MAXR : 4'd0;
        mode_q    <= mode;
        tgt_q     <= target_round;
      end else if (state == RUN) begin
        key_out   <= step_key;
        round_out <= step_rnd;
      end
    end
  end
endmodule

// File: tb/tb_aes_key_sched_seq.sv
// tb_aes_key_sched_seq: directed checks of the key schedule at 1 and 2 steps per cycle
module tb_aes_key_sched_seq;
  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KX  = 128'h0123456789abcdeffedcba9876543210;
  logic clk = 0, rst_n = 0, start = 0, mode = 0;
  logic [3:0] target_round = 0;
  logic [127:0] key_in = 0;
  logic busy, done, err, busy2, done2, err2;
  logic [127:0] key_out, key_out2;
  logic [3:0] round_out, round_out2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  aes_key_sched_seq #(.MAX_ROUND(10), .STEPS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .target_round(target_round),
    .key_in(key_in), .busy(busy), .done(done), .err(err), .key_out(key_out), .round_out(round_out));
  aes_key_sched_seq #(.MAX_ROUND(10), .STEPS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .target_round(target_round),
    .key_in(key_in), .busy(busy2), .done(done2), .err(err2), .key_out(key_out2), .round_out(round_out2));
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic m, input logic [3:0] t, input logic [127:0] k);
    mode = m;
    target_round = t;
    key_in = k;
    start = 1;
    tick;
    start = 0;
  endtask
  // Counts busy cycles from the current sample until both instances pulse done.
  task automatic run(input string tag, input logic [127:0] ek, input logic [3:0] er, input int eb1, input int eb2);
    int b1, b2;
    bit s1, s2;
    logic [127:0] k1, k2;
    logic [3:0] r1, r2;
    b1 = 0; b2 = 0; s1 = 0; s2 = 0; k1 = 0; k2 = 0; r1 = 0; r2 = 0;
    for (int c = 0; c < 40 && !(s1 && s2); c++) begin
      b1 += int'(busy);
      b2 += int'(busy2);
      if (done && !s1) begin s1 = 1; k1 = key_out; r1 = round_out; end
      if (done2 && !s2) begin s2 = 1; k2 = key_out2; r2 = round_out2; end
      if (!(s1 && s2)) tick;
    end
    check({tag, " done_seen"}, {126'd0, s1, s2}, 128'd3);
    check({tag, " busy1"}, 128'(b1), 128'(eb1));
    check({tag, " busy2"}, 128'(b2), 128'(eb2));
    check({tag, " key1"}, k1, ek);
    check({tag, " key2"}, k2, ek);
    check({tag, " rnd1"}, 128'(r1), 128'(er));
    check({tag, " rnd2"}, 128'(r2), 128'(er));
  endtask
  initial begin
    tick;
    tick;
    check("rst busy", 128'(busy), 0);
    check("rst done", 128'(done), 0);
    check("rst err", 128'(err), 0);
    check("rst key", key_out, 0);
    check("rst rnd", 128'(round_out), 0);
    rst_n = 1;
    tick;
    launch(0, 1, K0);
    run("fwd1", K1, 1, 1, 1);
    tick;
    launch(0, 10, K0);
    run("fwd10", K10, 10, 10, 5);
    tick;
    check("pulse done", 128'(done), 0);
    check("hold key", key_out, K10);
    check("hold rnd", 128'(round_out), 10);
    launch(1, 0, K10);
    run("inv0", K0, 0, 10, 5);
    tick;
    launch(1, 9, K10);
    run("inv9", K9, 9, 1, 1);
    tick;
    launch(1, 2, K10);
    run("inv2", K2, 2, 8, 4);
    tick;
    launch(0, 0, KX);
    run("zero_fwd", KX, 0, 0, 0);
    tick;
    launch(1, 10, KX);
    run("zero_inv", KX, 10, 0, 0);
    tick;
    launch(0, 11, K0);
    check("err pulse", 128'(err), 1);
    check("err pulse2", 128'(err2), 1);
    check("err busy", 128'(busy), 0);
    check("err key", key_out, KX);
    check("err rnd", 128'(round_out), 10);
    tick;
    check("err clear", 128'(err), 0);
    check("err nodone", 128'(done), 0);
    launch(1, 15, K0);
    check("err inv", 128'(err), 1);
    tick;
    launch(0, 10, K0);
    tick;
    mode = 1; target_round = 0; key_in = KX; start = 1;
    tick;
    start = 0;
    check("run start err", 128'(err), 0);
    check("run start busy", 128'(busy), 1);
    run("ignore", K10, 10, 8, 3);
    tick;
    launch(0, 1, K0);
    run("b2b first", K1, 1, 1, 1);
    check("b2b prev key", key_out, K1);
    launch(0, 10, K0);
    check("b2b busy", 128'(busy), 1);
    check("b2b nodone", 128'(done), 0);
    run("b2b second", K10, 10, 10, 5);
    tick;
    launch(0, 10, K0);
    tick;
    tick;
    check("mid busy", 128'(busy), 1);
    rst_n = 0;
    start = 1; mode = 0; target_round = 0; key_in = KX;
    tick;
    start = 0;
    check("mid rst busy", 128'(busy), 0);
    check("mid rst done", 128'(done), 0);
    check("mid rst key", key_out, 0);
    check("mid rst rnd", 128'(round_out), 0);
    tick;
    rst_n = 1;
    check("mid rst nodone", 128'(done | done2), 0);
    tick;
    tick;
    check("after rst done", 128'(done | done2 | busy | busy2), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
